// File: rtl/vend_pkg.sv
// vend_pkg: shared state type, coin/option codes and coin valuation for the vending sequencer
package vend_pkg;
  typedef enum logic [1:0] {IDLE, COLLECT, VEND, CHANGE} state_t;
  localparam logic [1:0] COIN_1 = 2'b00;
  localparam logic [1:0] COIN_2 = 2'b01;
  localparam logic [1:0] COIN_5 = 2'b10;
  localparam logic [1:0] COIN_10 = 2'b11;
  localparam logic [1:0] OPT_TEA = 2'b01;
  localparam logic [1:0] OPT_COFFEE = 2'b10;
  function automatic logic [4:0] coin_value(input logic [1:0] code);
    return code == COIN_10 ? 5'd10 : code == COIN_5 ? 5'd5 : code == COIN_2 ? 5'd2 : 5'd1;
  endfunction
endpackage

// File: rtl/vend_sequencer_if.sv
// vend_sequencer_if: customer, selection and change-hopper signals of the vending sequencer
interface vend_sequencer_if;
  logic enable;
  logic coin_valid;
  logic [1:0] coin_code;
  logic sel_valid;
  logic [1:0] option;
  logic cancel;
  logic chg_ready;
  logic coin_accept;
  logic coin_reject;
  logic err_option;
  logic short_credit;
  logic [4:0] credit;
  logic dispense;
  logic [1:0] product;
  logic chg_valid;
  logic [1:0] chg_code;
  logic busy;
  modport master (
    output enable, coin_valid, coin_code, sel_valid, option, cancel, chg_ready,
    input coin_accept, coin_reject, err_option, short_credit, credit, dispense, product,
    chg_valid, chg_code, busy
  );
  modport slave (
    input enable, coin_valid, coin_code, sel_valid, option, cancel, chg_ready,
    output coin_accept, coin_reject, err_option, short_credit, credit, dispense, product,
    chg_valid, chg_code, busy
  );
endinterface

// File: rtl/vend_change_pick.sv
// vend_change_pick: largest coin denomination not exceeding the given credit
module vend_change_pick
  import vend_pkg::*;
(
  input  logic [4:0] i_credit,
  output logic [1:0] o_chg_code
);
  always_comb
    o_chg_code = i_credit >= 5'd10 ? COIN_10 : i_credit >= 5'd5 ? COIN_5 : i_credit >= 5'd2 ? COIN_2 : COIN_1;
endmodule

// File: rtl/vend_sequencer.sv
// vend_sequencer: coin collection, product vend and greedy change return FSM
module vend_sequencer
  import vend_pkg::*;
#(
  parameter int PRICE_TEA = 5,
  parameter int PRICE_COFFEE = 10,
  parameter int CREDIT_MAX = 20
) (
  input logic clk,
  input logic rst_n,
  vend_sequencer_if.slave bus
);
  localparam logic [5:0] P_TEA = 6'(PRICE_TEA);
  localparam logic [5:0] P_COFFEE = 6'(PRICE_COFFEE);
  localparam logic [5:0] C_MAX = 6'(CREDIT_MAX);
  state_t r_state;
  logic [4:0] r_credit;
  logic [1:0] r_product, r_chg_code;
  logic r_coin_accept, r_coin_reject, r_err_option, r_short_credit, r_dispense, r_chg_valid;
  logic [4:0] w_coin_val, w_credit_left, w_pick_in;
  logic [5:0] w_sum, w_price;
  logic [1:0] w_pick;
  logic w_opt_ok, w_hs, w_coin_free;
  assign w_coin_val = coin_value(bus.coin_code);
  assign w_sum = {1'b0, r_credit} + {1'b0, w_coin_val};
  assign w_price = bus.option == OPT_TEA ? P_TEA : P_COFFEE;
  assign w_opt_ok = bus.option == OPT_TEA || bus.option == OPT_COFFEE;
  assign w_hs = r_chg_valid && bus.chg_ready;
  assign w_credit_left = r_credit - coin_value(r_chg_code);
  assign w_coin_free = bus.enable && !bus.cancel && !bus.sel_valid;
  // the next coin to offer is picked from the credit as it will be after this edge
  assign w_pick_in = (r_state == CHANGE && w_hs) ? w_credit_left : r_credit;
  vend_change_pick u_pick (.i_credit(w_pick_in), .o_chg_code(w_pick));
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_credit <= '0;
      r_product <= '0;
      r_chg_code <= '0;
      r_chg_valid <= 1'b0;
      r_coin_accept <= 1'b0;
      r_coin_reject <= 1'b0;
      r_err_option <= 1'b0;
      r_short_credit <= 1'b0;
      r_dispense <= 1'b0;
    end else begin
      r_coin_accept <= 1'b0;
      r_coin_reject <= 1'b0;
      r_err_option <= 1'b0;
      r_short_credit <= 1'b0;
      r_dispense <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.coin_valid && w_coin_free) begin
            r_coin_accept <= 1'b1;
            r_credit <= w_coin_val;
            r_state <= COLLECT;
          end else r_coin_reject <= bus.coin_valid;
        end
        COLLECT: begin
          if (bus.cancel || !bus.enable) begin
            r_coin_reject <= bus.coin_valid;
            r_chg_valid <= r_credit != 5'd0;
            r_chg_code <= w_pick;
            r_state <= CHANGE;
          end else if (bus.sel_valid) begin
            r_coin_reject <= bus.coin_valid;
            if (!w_opt_ok) r_err_option <= 1'b1;
            else if ({1'b0, r_credit} < w_price) r_short_credit <= 1'b1;
            else begin
              r_credit <= r_credit - w_price[4:0];
              r_product <= bus.option;
              r_dispense <= 1'b1;
              r_state <= VEND;
            end
          end else if (bus.coin_valid) begin
            if (w_sum <= C_MAX) begin
              r_coin_accept <= 1'b1;
              r_credit <= w_sum[4:0];
            end else r_coin_reject <= 1'b1;
          end
        end
        VEND: begin
          r_coin_reject <= bus.coin_valid;
          r_chg_valid <= r_credit != 5'd0;
          r_chg_code <= w_pick;
          r_state <= r_credit != 5'd0 ? CHANGE : IDLE;
        end
        CHANGE: begin
          r_coin_reject <= bus.coin_valid;
          if (w_hs) begin
            r_credit <= w_credit_left;
            r_chg_valid <= w_credit_left != 5'd0;
            r_chg_code <= w_pick;
            if (w_credit_left == 5'd0) r_state <= IDLE;
          end else if (r_credit == 5'd0) r_state <= IDLE;
        end
      endcase
    end
  end
  assign bus.coin_accept = r_coin_accept;
  assign bus.coin_reject = r_coin_reject;
  assign bus.err_option = r_err_option;
  assign bus.short_credit = r_short_credit;
  assign bus.credit = r_credit;
  assign bus.dispense = r_dispense;
  assign bus.product = r_product;
  assign bus.chg_valid = r_chg_valid;
  assign bus.chg_code = r_chg_code;
  assign bus.busy = r_state != IDLE;
endmodule

// File: doc/vend_sequencer.md
VEND_SEQUENCER -- requirements
Module: vend_sequencer

Interface
REQ-001 Parameter PRICE_TEA, default 5: price of tea in rupees.
REQ-002 Parameter PRICE_COFFEE, default 10: price of coffee in rupees.
REQ-003 Parameter CREDIT_MAX, default 20: maximum credit held; must be at most 31.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 rst_n  in  1  reset, synchronous and active-low.
REQ-006 enable  in  1  machine in service.
REQ-007 coin_valid  in  1  one coin presented this cycle.
REQ-008 coin_code  in  2  coin denomination: 00=Rs1, 01=Rs2, 10=Rs5, 11=Rs10.
REQ-009 sel_valid  in  1  product selection presented this cycle.
REQ-010 option  in  2  selection: 01=tea, 10=coffee; 00 and 11 are invalid.
REQ-011 cancel  in  1  refund request.
REQ-012 chg_ready  in  1  change hopper accepts the offered coin.
REQ-013 coin_accept  out  1  one-cycle pulse: coin credited.
REQ-014 coin_reject  out  1  one-cycle pulse: coin returned, not credited.
REQ-015 err_option  out  1  one-cycle pulse: invalid option.
REQ-016 short_credit  out  1  one-cycle pulse: credit below price.
REQ-017 credit  out  5  current credit in rupees.
REQ-018 dispense  out  1  one-cycle pulse: product released.
REQ-019 product  out  2  product code; valid with dispense and held until the next vend.
REQ-020 chg_valid  out  1  a change coin is offered.
REQ-021 chg_code  out  2  change coin denomination, same encoding as coin_code.
REQ-022 busy  out  1  high whenever the state is not IDLE.

Function
REQ-023 The FSM SHALL have exactly four states: IDLE, COLLECT, VEND and CHANGE.
REQ-024 Every response (accept, reject, error pulses, credit update) SHALL appear in the cycle after its input is sampled; all outputs are registered.
REQ-025 IDLE, coin arrives with enable=1: the coin is accepted, credit becomes the coin value, and the state moves to COLLECT.
REQ-026 COLLECT, coin arrives: the coin is accepted if credit plus coin value is at most CREDIT_MAX.
  - Accepted: the value is added to credit.
  - Otherwise: coin_reject pulses and credit is unchanged.
  - The sum is computed 6 bits wide, so no wrap-around.
REQ-027 COLLECT, selection arrives: the request is checked in this order.
  - Invalid option: err_option pulses; the state stays COLLECT.
  - Credit below price: short_credit pulses; the state stays COLLECT.
  - Otherwise: credit is reduced by the price, product is set to option, and the state moves to VEND.
REQ-028 Priority in one cycle SHALL be cancel, then sel_valid, then coin_valid.
  - Any coin arriving with cancel or sel_valid is rejected.
REQ-029 A cancel in COLLECT SHALL move the state to CHANGE with credit intact; a cancel in IDLE, VEND or CHANGE is ignored.
REQ-030 VEND SHALL last exactly one cycle with dispense=1, then move to CHANGE if credit > 0, otherwise to IDLE.
REQ-031 In CHANGE, chg_valid=1 while credit > 0.
  - chg_code is the largest denomination that does not exceed credit (10, 5, 2, 1).
  - When chg_valid and chg_ready are both high, credit drops by that value.
  - When credit reaches 0, chg_valid drops in the same cycle and the state returns to IDLE.
REQ-032 chg_code SHALL hold stable while chg_valid=1 and chg_ready=0.
REQ-033 With enable=0:
  - Coins are rejected in every state, and selections are ignored.
  - COLLECT with credit > 0 moves to CHANGE (forced refund).
  - VEND and CHANGE run to completion.
REQ-034 Credit SHALL never exceed CREDIT_MAX and never go below 0.

Reset
REQ-035 While rst_n=0 at a clock edge:
  - The state is IDLE.
  - credit, product and chg_code are 0.
  - All pulse outputs, chg_valid and busy are 0.
REQ-036 Reset during COLLECT, VEND or CHANGE SHALL discard credit with no refund and no dispense.

Structure
REQ-037 The shared package vend_pkg SHALL hold the state enum, the coin/option code constants and a coin-value function.
REQ-038 The greedy denomination selection SHALL be one combinational sub-module, vend_change_pick (credit in, chg_code out).

Verification
REQ-039 Reset, then coins 10, 2, 1, then select tea -> credit 13 then 8; dispense with product=01; change 5, 2, 1; then IDLE.
REQ-040 Coins 10, 10 (credit 20), then a 5 coin -> coin_reject and credit stays 20; select coffee -> dispense, change 10.
REQ-041 Credit 5, select coffee -> short_credit and stay in COLLECT; select option 11 -> err_option.
REQ-042 Credit 7, cancel and coin in the same cycle -> coin_reject, state CHANGE; change 5, 2; no dispense.
REQ-043 Change offered with chg_ready held low for 3 cycles -> chg_code stays constant and credit is unchanged.
REQ-044 Credit 12, drop enable -> refund 10, 2; coins while disabled -> coin_reject. Reset mid-CHANGE -> credit 0, state IDLE.
